// File: rtl/skin_threshold_calib.sv
// Skin-tone threshold calibration: measures Cb/Cr min/max over an ROI of one
// full frame and turns them into guard-banded thresholds for a skin thresholder.
module skin_threshold_calib #(
  parameter int MARGIN = 8,
  parameter int DEF_TA = 77,
  parameter int DEF_TB = 127,
  parameter int DEF_TC = 133,
  parameter int DEF_TD = 173
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        de,
  input  logic        vsync,
  input  logic [7:0]  Cb,
  input  logic [7:0]  Cr,
  input  logic        calib_start,
  input  logic [10:0] win_x0,
  input  logic [10:0] win_x1,
  input  logic [10:0] win_y0,
  input  logic [10:0] win_y1,
  output logic [7:0]  Ta,
  output logic [7:0]  Tb,
  output logic [7:0]  Tc,
  output logic [7:0]  Td,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, ACCUM, UPDATE} state_t;

  localparam logic signed [9:0] MG1 = 10'(MARGIN + 1);

  function automatic logic signed [9:0] ext10(input logic [7:0] v);
    return signed'({2'b00, v});
  endfunction

  function automatic logic [7:0] sat8(input logic signed [9:0] v);
    if (v < 10'sd0)
      return 8'd0;
    else if (v > 10'sd255)
      return 8'd255;
    else
      return v[7:0];
  endfunction

  state_t      state_q;
  logic        vsync_q, de_q;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic [7:0]  min_cb_q, max_cb_q, min_cr_q, max_cr_q;
  logic        pix_seen_q;
  logic [7:0]  ta_q, tb_q, tc_q, td_q;
  logic        busy_q, done_q, err_q;

  logic        vs_rise, in_roi;
  logic signed [9:0] ta_s, tb_s, tc_s, td_s;

  assign vs_rise = vsync & ~vsync_q;
  assign in_roi  = de && (x_q >= win_x0) && (x_q <= win_x1) &&
                   (y_q >= win_y0) && (y_q <= win_y1);

  assign ta_s = ext10(min_cb_q) - MG1;
  assign tb_s = ext10(max_cb_q) + MG1;
  assign tc_s = ext10(min_cr_q) - MG1;
  assign td_s = ext10(max_cr_q) + MG1;

  // Position counters: the current pixel always sees the pre-increment x/y
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (vs_rise) begin
      x_d = '0;
      y_d = '0;
    end else if (de) begin
      x_d = x_q + 11'd1;
    end else if (de_q) begin
      x_d = '0;
      y_d = y_q + 11'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
      de_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      vsync_q <= vsync;
      de_q    <= de;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      min_cb_q   <= '0;
      max_cb_q   <= '0;
      min_cr_q   <= '0;
      max_cr_q   <= '0;
      pix_seen_q <= 1'b0;
      ta_q       <= 8'(DEF_TA);
      tb_q       <= 8'(DEF_TB);
      tc_q       <= 8'(DEF_TC);
      td_q       <= 8'(DEF_TD);
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (calib_start) begin
            state_q <= WAIT_FRAME;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
          end
        end
        WAIT_FRAME: begin
          if (vs_rise) begin
            state_q    <= ACCUM;
            min_cb_q   <= 8'd255;
            min_cr_q   <= 8'd255;
            max_cb_q   <= 8'd0;
            max_cr_q   <= 8'd0;
            pix_seen_q <= 1'b0;
          end
        end
        ACCUM: begin
          // The pixel coinciding with the closing vsync belongs to the next frame
          if (vs_rise) begin
            state_q <= UPDATE;
          end else if (in_roi) begin
            if (Cb < min_cb_q) min_cb_q <= Cb;
            if (Cb > max_cb_q) max_cb_q <= Cb;
            if (Cr < min_cr_q) min_cr_q <= Cr;
            if (Cr > max_cr_q) max_cr_q <= Cr;
            pix_seen_q <= 1'b1;
          end
        end
        UPDATE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          if (pix_seen_q) begin
            ta_q <= sat8(ta_s);
            tb_q <= sat8(tb_s);
            tc_q <= sat8(tc_s);
            td_q <= sat8(td_s);
          end else begin
            err_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Ta   = ta_q;
  assign Tb   = tb_q;
  assign Tc   = tc_q;
  assign Td   = td_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_skin_threshold_calib.sv
// Directed bench for skin_threshold_calib: reset, uniform frame, saturation,
// ROI edges, empty ROI, ignored restarts and mid-calibration reset.
module tb_skin_threshold_calib;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        de, vsync, calib_start;
  logic [7:0]  Cb, Cr;
  logic [10:0] win_x0, win_x1, win_y0, win_y1;
  logic [7:0]  Ta, Tb, Tc, Td;
  logic        busy, done, err;

  int n_vec  = 0;
  int n_miss = 0;
  int done_cnt = 0;
  int d0;

  logic [7:0] cb_img [0:15][0:31];
  logic [7:0] cr_img [0:15][0:31];

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  skin_threshold_calib dut (
    .clk(clk), .rst_n(rst_n), .de(de), .vsync(vsync), .Cb(Cb), .Cr(Cr),
    .calib_start(calib_start),
    .win_x0(win_x0), .win_x1(win_x1), .win_y0(win_y0), .win_y1(win_y1),
    .Ta(Ta), .Tb(Tb), .Tc(Tc), .Td(Td), .busy(busy), .done(done), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_th(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d);
    chk({tag, ".Ta"}, Ta, a);
    chk({tag, ".Tb"}, Tb, b);
    chk({tag, ".Tc"}, Tc, c);
    chk({tag, ".Td"}, Td, d);
  endtask

  task automatic fill(input logic [7:0] cbv, input logic [7:0] crv);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 32; c++) begin
        cb_img[r][c] = cbv;
        cr_img[r][c] = crv;
      end
  endtask

  task automatic set_roi(input int x0, input int x1, input int y0, input int y1);
    win_x0 = 11'(x0); win_x1 = 11'(x1); win_y0 = 11'(y0); win_y1 = 11'(y1);
  endtask

  task automatic start_calib(input string tag);
    calib_start = 1'b1;
    tick();
    calib_start = 1'b0;
    chk({tag, ".busy_start"}, 8'(busy), 8'd1);
    chk({tag, ".err_start"}, 8'(err), 8'd0);
  endtask

  // Opening vsync rise followed by rows of pixels; inj >= 0 pulses calib_start
  // alongside that pixel index.
  task automatic send_frame(input int rows, input int cols, input int inj);
    int k;
    k = 0;
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
    tick();
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        de = 1'b1;
        Cb = cb_img[r][c];
        Cr = cr_img[r][c];
        calib_start = (k == inj);
        k++;
        tick();
      end
      calib_start = 1'b0;
      de = 1'b0;
      tick();
      tick();
    end
  endtask

  task automatic close_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d,
                             input logic e, input logic poke_update);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    chk({tag, ".done_n1"}, 8'(done), 8'd0);
    chk({tag, ".busy_n1"}, 8'(busy), 8'd1);
    calib_start = poke_update;
    tick();
    calib_start = 1'b0;
    chk({tag, ".done_n2"}, 8'(done), 8'd1);
    chk({tag, ".busy_n2"}, 8'(busy), 8'd0);
    chk({tag, ".err"}, 8'(err), 8'(e));
    chk_th(tag, a, b, c, d);
    tick();
    chk({tag, ".done_n3"}, 8'(done), 8'd0);
    chk({tag, ".busy_n3"}, 8'(busy), 8'd0);
  endtask

  initial begin
    rst_n = 1'b0; de = 1'b0; vsync = 1'b0; calib_start = 1'b0;
    Cb = 8'd0; Cr = 8'd0;
    set_roi(0, 15, 0, 7);
    tick();
    tick();
    chk_th("reset", 8'd77, 8'd127, 8'd133, 8'd173);
    chk("reset.busy", 8'(busy), 8'd0);
    chk("reset.done", 8'(done), 8'd0);
    chk("reset.err", 8'(err), 8'd0);
    rst_n = 1'b1;
    tick();
    tick();

    // Uniform frame; calib_start poked during UPDATE must be ignored
    fill(8'd100, 8'd150);
    set_roi(0, 15, 0, 7);
    d0 = done_cnt;
    start_calib("uni");
    send_frame(8, 16, -1);
    close_frame("uni", 8'd91, 8'd109, 8'd141, 8'd159, 1'b0, 1'b1);
    repeat (4) tick();
    chk("uni.busy_after", 8'(busy), 8'd0);
    chk("uni.done_count", 8'(done_cnt - d0), 8'd1);

    // Saturation at both ends
    fill(8'd128, 8'd128);
    cb_img[0][1] = 8'd3;
    cb_img[1][2] = 8'd250;
    cr_img[0][3] = 8'd0;
    cr_img[1][0] = 8'd255;
    set_roi(0, 3, 0, 1);
    start_calib("sat");
    send_frame(4, 6, -1);
    close_frame("sat", 8'd0, 8'd255, 8'd0, 8'd255, 1'b0, 1'b0);

    // ROI column edge: x=win_x1 counts, x=win_x1+1 does not
    fill(8'd100, 8'd150);
    cb_img[1][7] = 8'd60;
    cb_img[1][8] = 8'd10;
    set_roi(0, 7, 0, 3);
    start_calib("edge");
    send_frame(6, 12, -1);
    close_frame("edge", 8'd51, 8'd109, 8'd141, 8'd159, 1'b0, 1'b0);

    // Empty ROI: err set, thresholds held, err cleared by next accepted start
    set_roi(5, 4, 0, 3);
    start_calib("empty");
    send_frame(4, 8, -1);
    close_frame("empty", 8'd51, 8'd109, 8'd141, 8'd159, 1'b1, 1'b0);
    repeat (3) tick();
    chk("empty.err_hold", 8'(err), 8'd1);

    // Second calib_start during ACCUM is ignored
    fill(8'd50, 8'd200);
    set_roi(0, 7, 0, 3);
    d0 = done_cnt;
    start_calib("restart");
    send_frame(4, 8, 10);
    close_frame("restart", 8'd41, 8'd59, 8'd191, 8'd209, 1'b0, 1'b0);
    send_frame(4, 8, -1);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    repeat (4) tick();
    chk("restart.done_count", 8'(done_cnt - d0), 8'd1);
    chk("restart.busy", 8'(busy), 8'd0);

    // Reset in the middle of ACCUM aborts without a done pulse
    fill(8'd20, 8'd30);
    d0 = done_cnt;
    start_calib("abort");
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
    de = 1'b1; Cb = 8'd20; Cr = 8'd30;
    repeat (5) tick();
    de = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_th("abort", 8'd77, 8'd127, 8'd133, 8'd173);
    chk("abort.busy", 8'(busy), 8'd0);
    chk("abort.done", 8'(done), 8'd0);
    chk("abort.err", 8'(err), 8'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    repeat (4) tick();
    chk("abort.done_count", 8'(done_cnt - d0), 8'd0);
    chk("abort.busy_after", 8'(busy), 8'd0);
    chk_th("abort_after", 8'd77, 8'd127, 8'd133, 8'd173);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
